// File: rtl/centipede_loader_pkg.sv
// centipede_loader_pkg: shared FSM states, region bases and offset type for the Centipede ROM loader
package centipede_loader_pkg;
  localparam int PROG_SIZE_DEF = 8192;
  localparam int GFX_SIZE_DEF = 4096;
  localparam int PROG_BASE = 0;
  localparam int GFX_BASE = PROG_SIZE_DEF;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RELEASE, RUN} loader_state_t;
  typedef logic [12:0] rom_off_t;
endpackage

// File: rtl/loader_addr_decode.sv
// loader_addr_decode: splits a 25-bit image address into program/graphics region and region-relative offset
module loader_addr_decode
  import centipede_loader_pkg::*;
#(
  parameter int PROG_SIZE = PROG_SIZE_DEF,
  parameter int GFX_SIZE = GFX_SIZE_DEF
) (
  input  logic [24:0] addr,
  output logic        region_prog,
  output logic        region_gfx,
  output logic        out_of_range,
  output rom_off_t    offset
);
  localparam logic [24:0] GFX_LO = 25'(PROG_BASE + PROG_SIZE);
  localparam logic [24:0] GFX_HI = 25'(PROG_BASE + PROG_SIZE + GFX_SIZE);
  assign region_prog = addr < GFX_LO;
  assign region_gfx = !region_prog && addr < GFX_HI;
  assign out_of_range = !region_prog && !region_gfx;
  assign offset = rom_off_t'(region_gfx ? addr - GFX_LO : addr);
endmodule

// File: rtl/centipede_rom_loader.sv
// centipede_rom_loader: feeds the ioctl download into the program/graphics ROM write port; ROM_LOADER_CHECKSUM_EN adds a byte checksum output
module centipede_rom_loader
  import centipede_loader_pkg::*;
#(
  parameter logic [7:0] ROM_INDEX = 8'h00,
  parameter int PROG_SIZE = PROG_SIZE_DEF,
  parameter int GFX_SIZE = GFX_SIZE_DEF,
  parameter int RESET_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        prog_we,
  output logic        gfx_we,
  output logic [12:0] rom_addr,
  output logic [7:0]  rom_data,
  input  logic        rom_ready,
  output logic        core_reset,
  output logic        loaded,
`ifdef ROM_LOADER_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic        load_err
);
  localparam int CW = $clog2(RESET_HOLD + 1);
  loader_state_t state;
  logic [CW-1:0] cnt;
  logic active, active_q, region_prog, region_gfx, out_of_range;
  rom_off_t offset;
  assign active = ioctl_download && ioctl_index == ROM_INDEX;
  loader_addr_decode #(.PROG_SIZE(PROG_SIZE), .GFX_SIZE(GFX_SIZE)) u_dec (
    .addr(ioctl_addr),
    .region_prog(region_prog),
    .region_gfx(region_gfx),
    .out_of_range(out_of_range),
    .offset(offset)
  );
  // download sequencer: capture a byte, hold the write until the ROM takes it, then count out the core reset
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      active_q <= 1'b0;
      cnt <= '0;
      ioctl_wait <= 1'b0;
      prog_we <= 1'b0;
      gfx_we <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
      core_reset <= 1'b1;
      loaded <= 1'b0;
      load_err <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      active_q <= active;
      case (state)
        IDLE, RUN: if (active && !active_q) begin
          state <= LOAD;
          core_reset <= 1'b1;
          loaded <= 1'b0;
          load_err <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
          checksum <= '0;
`endif
        end
        LOAD: if (!active) begin
          state <= RELEASE;
          cnt <= CW'(RESET_HOLD);
        end else if (ioctl_wr) begin
          if (out_of_range) load_err <= 1'b1;
          else begin
            rom_addr <= offset;
            rom_data <= ioctl_dout;
            prog_we <= region_prog;
            gfx_we <= region_gfx;
            ioctl_wait <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (ioctl_wr) load_err <= 1'b1;
          if (rom_ready) begin
            prog_we <= 1'b0;
            gfx_we <= 1'b0;
            ioctl_wait <= 1'b0;
            cnt <= CW'(RESET_HOLD);
            state <= active ? LOAD : RELEASE;
`ifdef ROM_LOADER_CHECKSUM_EN
            checksum <= checksum + 16'(rom_data);
`endif
          end
        end
        RELEASE: if (active) begin
          state <= LOAD;
          load_err <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
          checksum <= '0;
`endif
        end else if (cnt == CW'(1)) begin
          core_reset <= 1'b0;
          loaded <= 1'b1;
          state <= RUN;
        end else cnt <= cnt - CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
